imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have the parameter IMEM_DEPTH, default 4096, giving the number of 16-bit instruction-memory words; PC saturation is at 0x0fff.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: requests a new program load.
REQ-005 The block SHALL have port rx_valid, input, 1 bit: a byte is offered on rx_data.
REQ-006 The block SHALL have port rx_data, input, 8 bits: the offered byte.
REQ-007 The block SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 The block SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-009 The block SHALL have port imem_addr, output, 16 bits: word address of the write.
REQ-010 The block SHALL have port imem_wdata, output, 16 bits: instruction word to write.
REQ-011 The block SHALL have port core_rst, output, 1 bit: holds the pipelined core in reset while high.
REQ-012 The block SHALL have port done, output, 1 bit: the load completed successfully.
REQ-013 The block SHALL have port err, output, 1 bit: the load was aborted.

Function
REQ-014 The block SHALL implement the states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE and ERROR.
REQ-015 A byte SHALL be accepted on a rising edge only when rx_valid=1 and rx_ready=1.
REQ-016 rx_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
REQ-017 A start pulse in IDLE or DONE SHALL move the block to LEN_HI, clear done, set the address to 0 and set core_rst=1; start SHALL be ignored in every other state.
REQ-018 The stream format SHALL be: word count N as two bytes, high byte first, followed by N words of two bytes each, high byte first.
REQ-019 After LEN_LO accepts its byte, N=0 or N>IMEM_DEPTH SHALL lead to ERROR; otherwise the block SHALL go to DATA_HI.
REQ-020 Acceptance in DATA_LO SHALL lead to WRITE, which lasts exactly one cycle with imem_we=1, imem_addr equal to the word index and imem_wdata={hi,lo}.
REQ-021 On leaving WRITE the address SHALL increment; if N words have now been written, the block SHALL go to CHK (macro defined) or DONE, otherwise to DATA_HI.
REQ-022 imem_we SHALL be 0 in every state except WRITE.
REQ-023 The words of a load SHALL be written once each, in order, to addresses 0 to N-1; the minimum cost SHALL be three cycles per word (two bytes plus one write cycle).
REQ-024 The width rules SHALL be: N is 16 bits compared unsigned; the address counter never exceeds IMEM_DEPTH-1 on a write.
REQ-025 In DONE the outputs SHALL be done=1 and core_rst=0, and the block SHALL remain in DONE until start or rst.
REQ-026 In ERROR the outputs SHALL be err=1 and core_rst=1, and the block SHALL remain in ERROR until rst; start SHALL be ignored there.
REQ-027 A stall with rx_valid=0 in any receive state SHALL hold all state with no timeout.
REQ-028 imem_addr and imem_wdata SHALL hold their last values outside WRITE.

Reset
REQ-029 On rst=1 at a rising edge the block SHALL go to IDLE, with rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0 and err=0.
REQ-030 rst SHALL take priority over start and rx_valid.
REQ-031 A rst mid-load SHALL discard the partial load without issuing any further write.

Configuration
REQ-032 With IMEM_LOADER_CHECKSUM_EN defined, CHK SHALL accept one byte equal to the XOR of all data bytes; a match SHALL lead to DONE and a mismatch to ERROR.
REQ-033 With IMEM_LOADER_CHECKSUM_EN undefined, CHK SHALL be unreachable and no checksum byte SHALL be consumed.

Verification
REQ-034 Scenario, basic load: rst, start, then bytes 00 02 12 34 AB CD with rx_valid held high -> writes 0x1234@0 and 0xABCD@1, then done=1 and core_rst=0.
REQ-035 Scenario, zero length: start, then bytes 00 00 -> err=1, core_rst=1, no imem_we; a later start is ignored.
REQ-036 Scenario, over-length: bytes 10 01 (N=4097) -> ERROR; bytes 10 00 (N=4096) -> full load with the last write at address 0x0fff.
REQ-037 Scenario, backpressure: rx_valid toggled 1/0 every cycle during 00 01 55 AA -> a single write of 0x55AA@0 and exactly four bytes consumed.
REQ-038 Scenario, reset mid-load: rst asserted after 00 03 11 22 33 -> IDLE, only 0x1122@0 was written, core_rst=1.
REQ-039 Scenario, checksum (macro defined): 00 01 0F F0 FF -> done=1; 00 01 0F F0 00 -> err=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream, writes it into instruction memory and holds
// the core in reset until the load completes. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int unsigned IMEM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHK     = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] len_r;
    logic [15:0] addr_r;
    logic [7:0]  hi_r;
    logic [15:0] imem_addr_r;
    logic [15:0] imem_wdata_r;
    logic        rx_ready_r;
    logic        imem_we_r;
    logic        core_rst_r;
    logic        done_r;
    logic        err_r;
    logic        accept_s;
    logic        len_bad_s;
    logic        last_word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk_r;
`endif

    assign accept_s    = rx_valid & rx_ready_r;
    assign len_bad_s   = ({len_r[15:8], rx_data} == 16'd0) ||
                         (32'({len_r[15:8], rx_data}) > IMEM_DEPTH);
    assign last_word_s = ((addr_r + 16'd1) == len_r);

    assign rx_ready   = rx_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign core_rst   = core_rst_r;
    assign done       = done_r;
    assign err        = err_r;

    // Next-state decode; start is honoured only from IDLE or DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) state_next_s = LEN_HI;
                else       state_next_s = state_r;
            end
            LEN_HI: begin
                if (accept_s) state_next_s = LEN_LO;
                else          state_next_s = LEN_HI;
            end
            LEN_LO: begin
                if (accept_s) state_next_s = len_bad_s ? ERROR : DATA_HI;
                else          state_next_s = LEN_LO;
            end
            DATA_HI: begin
                if (accept_s) state_next_s = DATA_LO;
                else          state_next_s = DATA_HI;
            end
            DATA_LO: begin
                if (accept_s) state_next_s = WRITE;
                else          state_next_s = DATA_LO;
            end
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (last_word_s) state_next_s = CHK;
`else
                if (last_word_s) state_next_s = DONE;
`endif
                else             state_next_s = DATA_HI;
            end
            CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept_s) state_next_s = (rx_data == chk_r) ? DONE : ERROR;
                else          state_next_s = CHK;
`else
                state_next_s = ERROR;
`endif
            end
            ERROR:   state_next_s = ERROR;
            default: state_next_s = IDLE;
        endcase
    end

    // State, registered outputs (decoded from the next state) and load datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            len_r        <= 16'd0;
            addr_r       <= 16'd0;
            hi_r         <= 8'd0;
            imem_addr_r  <= 16'd0;
            imem_wdata_r <= 16'd0;
            rx_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            core_rst_r   <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_r        <= 8'd0;
`endif
        end else begin
            state_r    <= state_next_s;
            rx_ready_r <= (state_next_s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK});
            imem_we_r  <= (state_next_s == WRITE);
            core_rst_r <= (state_next_s != DONE);
            done_r     <= (state_next_s == DONE);
            err_r      <= (state_next_s == ERROR);
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        addr_r <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_r  <= 8'd0;
`endif
                    end
                end
                LEN_HI:  if (accept_s) len_r[15:8] <= rx_data;
                LEN_LO:  if (accept_s) len_r[7:0] <= rx_data;
                DATA_HI: begin
                    if (accept_s) begin
                        hi_r  <= rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_r <= chk_r ^ rx_data;
`endif
                    end
                end
                // The write port is loaded here so it holds its value outside WRITE.
                DATA_LO: begin
                    if (accept_s) begin
                        imem_addr_r  <= addr_r;
                        imem_wdata_r <= {hi_r, rx_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_r        <= chk_r ^ rx_data;
`endif
                    end
                end
                WRITE:   addr_r <= addr_r + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a stream-level reference model.
// Compile with IMEM_LOADER_CHECKSUM_EN to match a checksum-enabled build.
module tb_imem_loader;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    int          total = 0;
    int          bad = 0;
    int          byte_cnt = 0;
    int          g0;
    int          b0;
    bit          m_err;
    int          m_bytes;
    logic [7:0]  stream_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Observe writes and consumed bytes midway between active edges.
    always @(negedge clk) begin
        if (imem_we) got_q.push_back({imem_addr, imem_wdata});
        if (rx_valid && rx_ready) byte_cnt++;
    end

    // Reference: decode the stream as a whole into expected writes, outcome and bytes consumed.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_q.delete();
        m_err = 1'b0;
        x = 8'd0;
        n = int'({stream_q[0], stream_q[1]});
        if (n == 0 || n > DEPTH) begin
            m_err = 1'b1;
            m_bytes = 2;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({16'(i), stream_q[2 + 2 * i], stream_q[3 + 2 * i]});
                x = x ^ stream_q[2 + 2 * i] ^ stream_q[3 + 2 * i];
            end
            m_bytes = 2 + 2 * n;
`ifdef IMEM_LOADER_CHECKSUM_EN
            m_bytes = m_bytes + 1;
            if (stream_q[m_bytes - 1] != x) m_err = 1'b1;
`endif
        end
    endtask

    task automatic append_chk(input bit corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        for (int i = 2; i < stream_q.size(); i++) x = x ^ stream_q[i];
        stream_q.push_back(corrupt ? ~x : x);
`else
        if (corrupt) stream_q.push_back(8'h00);
        else         stream_q.push_back(8'h00);
        void'(stream_q.pop_back());
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_load(input string name, input bit toggle, input bit stall,
                            input bit rnd_start, input bit wait_end);
        int i;
        int cyc;
        bit v;
        bit ph;
        bit r;
        if (wait_end) model();
        g0 = got_q.size();
        b0 = byte_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        i = 0; cyc = 0; ph = 1'b1;
        while (i < stream_q.size() && cyc < 8 * stream_q.size() + 200) begin
            if (toggle) begin v = ph; ph = ~ph; end
            else if (stall) v = ($urandom_range(0, 3) != 0);
            else v = 1'b1;
            rx_valid = v;
            rx_data = v ? stream_q[i] : 8'($urandom);
            start = rnd_start ? 1'($urandom) : 1'b0;
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            #1;
            if (v && r) i++;
            cyc++;
        end
        rx_valid = 1'b0; start = 1'b0;
        total++;
        if (i != stream_q.size()) begin
            bad++; $display("FAIL %s_feed: bytes taken=%0d required=%0d", name, i, stream_q.size());
        end
        if (wait_end) begin
            cyc = 0;
            while (!(done || err) && cyc < 100) begin @(posedge clk); #1; cyc++; end
            total++;
            if (!(done || err)) begin
                bad++; $display("FAIL %s_end: done=%0b err=%0b required one of them set", name, done, err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got=%b required=0", rx_ready); end
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got=%b required=0", imem_we); end
        total++; if ({imem_addr, imem_wdata} !== 32'h0) begin bad++; $display("FAIL reset_addr_data: got=%h required=0", {imem_addr, imem_wdata}); end
        total++; if ({core_rst, done, err} !== 3'b100) begin bad++; $display("FAIL reset_flags: got=%b required=100", {core_rst, done, err}); end
        start = 1'b0;
        #1 rst = 1'b0;
        b0 = byte_cnt;
        repeat (4) @(posedge clk);
        #1;
        total++; if (rx_ready !== 1'b0 || byte_cnt != b0) begin bad++; $display("FAIL idle_no_accept: rx_ready=%b bytes=%0d required 0/0", rx_ready, byte_cnt - b0); end
        rx_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        stream_q.delete();
        stream_q.push_back(8'h00); stream_q.push_back(8'h02); stream_q.push_back(8'h12);
        stream_q.push_back(8'h34); stream_q.push_back(8'hAB); stream_q.push_back(8'hCD);
        append_chk(1'b0);
        run_load("basic", 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if ({done, err, core_rst} !== 3'b100) begin bad++; $display("FAIL basic_flags: got=%b required=100", {done, err, core_rst}); end
        total++; if (got_q.size() - g0 != 2) begin bad++; $display("FAIL basic_wcount: got=%0d required=2", got_q.size() - g0); end
        else begin
            total++; if (got_q[g0] !== 32'h0000_1234) begin bad++; $display("FAIL basic_w0: got=%h required=00001234", got_q[g0]); end
            total++; if (got_q[g0 + 1] !== 32'h0001_ABCD) begin bad++; $display("FAIL basic_w1: got=%h required=0001abcd", got_q[g0 + 1]); end
        end
        total++; if (byte_cnt - b0 != stream_q.size()) begin bad++; $display("FAIL basic_bytes: got=%0d required=%0d", byte_cnt - b0, stream_q.size()); end
    endtask

    task automatic test_zero_len();
        do_reset();
        stream_q.delete(); stream_q.push_back(8'h00); stream_q.push_back(8'h00);
        run_load("zero", 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if ({done, err, core_rst} !== 3'b011) begin bad++; $display("FAIL zero_flags: got=%b required=011", {done, err, core_rst}); end
        total++; if (got_q.size() != g0) begin bad++; $display("FAIL zero_writes: got=%0d required=0", got_q.size() - g0); end
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({err, rx_ready, done, core_rst} !== 4'b1001) begin bad++; $display("FAIL zero_start_ignored: got=%b required=1001", {err, rx_ready, done, core_rst}); end
    endtask

    task automatic test_over_len();
        int mis;
        do_reset();
        stream_q.delete(); stream_q.push_back(8'h10); stream_q.push_back(8'h01);
        run_load("over", 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if ({err, done, got_q.size() == g0} !== 3'b101) begin bad++; $display("FAIL over_4097: err/done/nowrite got=%b required=101", {err, done, got_q.size() == g0}); end
        do_reset();
        stream_q.delete(); stream_q.push_back(8'h10); stream_q.push_back(8'h00);
        for (int i = 0; i < 2 * DEPTH; i++) stream_q.push_back(8'($urandom));
        append_chk(1'b0);
        run_load("full", 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL full_flags: got=%b required=10", {done, err}); end
        total++; if (got_q.size() - g0 != DEPTH) begin bad++; $display("FAIL full_wcount: got=%0d required=%0d", got_q.size() - g0, DEPTH); end
        else begin
            total++; if (got_q[g0 + DEPTH - 1][31:16] !== 16'h0fff) begin bad++; $display("FAIL full_last_addr: got=%h required=0fff", got_q[g0 + DEPTH - 1][31:16]); end
            mis = 0;
            for (int i = 0; i < DEPTH; i++) if (got_q[g0 + i] !== exp_q[i]) mis++;
            total++; if (mis != 0) begin bad++; $display("FAIL full_words: wrong=%0d required=0", mis); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        stream_q.delete();
        stream_q.push_back(8'h00); stream_q.push_back(8'h01); stream_q.push_back(8'h55); stream_q.push_back(8'hAA);
        append_chk(1'b0);
        run_load("bp", 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL bp_flags: got=%b required=10", {done, err}); end
        total++; if (got_q.size() - g0 != 1 || got_q[g0] !== 32'h0000_55AA) begin bad++; $display("FAIL bp_write: count=%0d required=1 of 000055aa", got_q.size() - g0); end
        total++; if (byte_cnt - b0 != stream_q.size()) begin bad++; $display("FAIL bp_bytes: got=%0d required=%0d", byte_cnt - b0, stream_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stream_q.delete();
        stream_q.push_back(8'h00); stream_q.push_back(8'h03); stream_q.push_back(8'h11);
        stream_q.push_back(8'h22); stream_q.push_back(8'h33);
        run_load("mid", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        total++; if ({rx_ready, imem_we, core_rst, done, err} !== 5'b00100) begin bad++; $display("FAIL mid_idle: got=%b required=00100", {rx_ready, imem_we, core_rst, done, err}); end
        rx_valid = 1'b1; rx_data = 8'h44;
        repeat (6) @(posedge clk);
        #1 rx_valid = 1'b0;
        total++; if (got_q.size() - g0 != 1 || got_q[g0] !== 32'h0000_1122) begin bad++; $display("FAIL mid_writes: count=%0d required=1 of 00001122", got_q.size() - g0); end
        total++; if (byte_cnt - b0 != 5) begin bad++; $display("FAIL mid_bytes: got=%0d required=5", byte_cnt - b0); end
    endtask

    task automatic test_random();
        int n;
        int mis;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 24);
            stream_q.delete();
            stream_q.push_back(8'(n >> 8)); stream_q.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) stream_q.push_back(8'($urandom));
            append_chk($urandom_range(0, 3) == 0);
            run_load("rand", 1'b0, 1'b1, 1'b1, 1'b1);
            total++; if ({done, err, core_rst} !== {~m_err, m_err, m_err}) begin bad++; $display("FAIL rand_flags: got=%b required=%b", {done, err, core_rst}, {~m_err, m_err, m_err}); end
            mis = (got_q.size() - g0 == exp_q.size()) ? 0 : 1;
            for (int i = 0; i < exp_q.size() && mis == 0; i++) if (got_q[g0 + i] !== exp_q[i]) mis++;
            total++; if (mis != 0) begin bad++; $display("FAIL rand_writes: count=%0d required=%0d", got_q.size() - g0, exp_q.size()); end
            total++; if (byte_cnt - b0 != m_bytes) begin bad++; $display("FAIL rand_bytes: got=%0d required=%0d", byte_cnt - b0, m_bytes); end
            if (err) do_reset();
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            stream_q.delete();
            stream_q.push_back(8'h00); stream_q.push_back(8'h01); stream_q.push_back(8'h0F);
            stream_q.push_back(8'hF0); stream_q.push_back(k == 0 ? 8'hFF : 8'h00);
            run_load("chk", 1'b0, 1'b0, 1'b0, 1'b1);
            total++; if ({done, err} !== (k == 0 ? 2'b10 : 2'b01)) begin bad++; $display("FAIL chk_%0d: done/err got=%b", k, {done, err}); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_over_len();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
